// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter with optional message locking, driving one
// shared 8N1 (LSB-first) serial transmit line.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 106,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 ser_tx,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 locked
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n, grant_n, pick;
    logic          locked_n, hit;
    logic [TW-1:0] timer, timer_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    ready8, valid8, last8;
    logic [63:0]   data8;

    assign valid8 = 8'(req_valid);
    assign last8  = 8'(req_last);
    assign data8  = 64'(req_data);

    function automatic logic [2:0] wrap_add(input logic [2:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return 3'(s);
    endfunction

    // Lowest offset from the pointer wins, so scan downward and overwrite.
    always_comb begin
        hit  = 1'b0;
        pick = grant_id;
        if (locked) begin
            hit = valid8[grant_id];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (valid8[wrap_add(ptr, k)]) begin
                    hit  = 1'b1;
                    pick = wrap_add(ptr, k);
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant_id;
        locked_n = locked;
        timer_n  = timer;
        baud_n   = baud;
        bitn_n   = bitn;
        shift_n  = shift;
        ready8   = '0;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                bitn_n = '0;
                if (hit) begin
                    ready8[pick] = 1'b1;
                    shift_n  = data8[{pick, 3'b000} +: 8];
                    grant_n  = pick;
                    locked_n = !last8[pick];
                    timer_n  = '0;
                    if (!locked) ptr_n = wrap_add(pick, 1);
                    state_n  = START;
                end else if (locked) begin
                    if (timer == TMO_LAST) begin
                        locked_n = 1'b0;
                        timer_n  = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    bitn_n  = bitn + 3'd1;
                    if (bitn == 3'd7) state_n = STOP;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
            timer    <= '0;
            baud     <= '0;
            bitn     <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= grant_n;
            locked   <= locked_n;
            timer    <= timer_n;
            baud     <= baud_n;
            bitn     <= bitn_n;
            shift    <= shift_n;
        end
    end

    assign req_ready = resetn ? ready8[NUM_REQ-1:0] : '0;
    assign busy      = (state != IDLE);
    assign ser_tx    = (state == START) ? 1'b0 :
                       (state == DATA)  ? shift[0] : 1'b1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: a transaction model predicts accepts and frames,
// a line monitor decodes ser_tx and compares against the predictions.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int C     = 106;
    localparam int LT    = 16;
    localparam int FRAME = 10 * C;

    logic            clk       = 1'b0;
    logic            resetn    = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   req_last  = '0;
    logic [NR-1:0]   req_ready;
    logic            ser_tx, busy, locked;
    logic [2:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .CLKS_PER_BIT(C),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .ser_tx(ser_tx),
        .busy(busy),
        .grant_id(grant_id),
        .locked(locked)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    // Per-requester message queues: {last, data}
    logic [8:0]    mq [NR][256];
    int            hd [NR];
    int            tl [NR];
    bit            en [NR];
    bit            churn   = 1'b0;
    bit            rst_req = 1'b1;
    logic [NR-1:0] acc_now;
    int            acc_log[$];
    longint        acc_cyc[$];

    typedef struct {
        logic [7:0] data;
        int         id;
        bit         lk;
        longint     acc;
    } exp_t;
    exp_t exp_q[$];

    int            m_ptr, m_hold, m_idle;
    bit            m_lock;
    longint        m_free;
    logic [NR-1:0] exp_rdy;

    // Transaction model: line is free again FRAME+1 cycles after an accept.
    task automatic model_step();
        int   win;
        exp_t e;
        exp_rdy = '0;
        win = -1;
        if (!resetn) begin
            m_ptr = 0; m_hold = 0; m_idle = 0; m_lock = 0; m_free = 0;
            exp_q.delete();
        end else if (cyc >= m_free) begin
            if (m_lock) begin
                if (req_valid[m_hold]) begin
                    win = m_hold;
                end else begin
                    m_idle++;
                    if (m_idle == LT) begin
                        m_lock = 0;
                        m_idle = 0;
                    end
                end
            end else begin
                for (int k = 0; k < NR; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % NR])
                        win = (m_ptr + k) % NR;
            end
            if (win >= 0) begin
                exp_rdy[win] = 1'b1;
                e.data = req_data[win*8 +: 8];
                e.id   = win;
                e.lk   = !req_last[win];
                e.acc  = cyc;
                exp_q.push_back(e);
                if (!m_lock) m_ptr = (win + 1) % NR;
                m_lock = !req_last[win];
                m_hold = win;
                m_idle = 0;
                m_free = cyc + FRAME + 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        resetn = !rst_req;
        for (int i = 0; i < NR; i++) begin
            if (hd[i] != tl[i]) begin
                if (churn && $urandom_range(0, 3) == 0)
                    mq[i][hd[i]][7:0] = 8'($urandom);
                req_valid[i]       = en[i];
                req_data[i*8 +: 8] = mq[i][hd[i]][7:0];
                req_last[i]        = mq[i][hd[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        #2;
        model_step();
        if (exp_rdy != '0 || req_ready != '0)
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
        acc_now = req_valid & req_ready;
        for (int i = 0; i < NR; i++) begin
            if (acc_now[i]) begin
                hd[i]++;
                acc_log.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mq[i][tl[i]] = {l, d};
        tl[i]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++)
            if (hd[i] != tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] ord_code();
        logic [63:0] r = '0;
        foreach (acc_log[k]) r = (r << 4) | 64'(acc_log[k] + 1);
        return r;
    endfunction

    function automatic longint gap(input int a, input int b);
        if (acc_cyc.size() <= b) return -1;
        return acc_cyc[b] - acc_cyc[a];
    endfunction

    task automatic apply_reset();
        rst_req = 1'b1;
        tick();
        tick();
        check("rst_ser_tx", 64'(ser_tx), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        tick();
        rst_req = 1'b0;
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n = 0;
        while ((pending() || exp_q.size() != 0) && n < budget) begin
            if (rnd)
                for (int i = 0; i < NR; i++)
                    en[i] = ($urandom_range(0, 4) != 0);
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: timeout after %0d cycles, %0d frames outstanding",
                     n, exp_q.size());
        end
        for (int i = 0; i < NR; i++) en[i] = 1'b1;
    endtask

    task automatic wait_acc(input int i, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!acc_now[i] && n < budget);
        if (!acc_now[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_acc: requester %0d not accepted in %0d cycles",
                     i, budget);
        end
    endtask

    // Line monitor: samples every frame cycle, decodes the byte and pops.
    initial begin : monitor
        longint     s;
        logic [9:0] val;
        bit         bad, abort;
        logic [2:0] g;
        logic       lk;
        exp_t       e;
        forever begin
            @(negedge clk);
            #3;
            if (resetn === 1'b1 && ser_tx === 1'b0) begin
                s = cyc; val = '1; bad = 0; abort = 0;
                g = grant_id; lk = locked;
                for (int k = 0; k <= FRAME; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        #3;
                    end
                    if (resetn !== 1'b1) begin
                        abort = 1;
                        break;
                    end
                    if (k == FRAME) begin
                        if (busy !== 1'b0 || ser_tx !== 1'b1) bad = 1;
                    end else begin
                        if (busy !== 1'b1) bad = 1;
                        if (k % C == 0) val[k / C] = ser_tx;
                        else if (ser_tx !== val[k / C]) bad = 1;
                    end
                end
                if (!abort) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame: unexpected byte %02h at cycle %0d",
                                 val[8:1], s);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", 64'(val[8:1]), 64'(e.data));
                        check("frame_id", 64'(g), 64'(e.id));
                        check("frame_lock", 64'(lk), 64'(e.lk));
                        check("frame_start", 64'(s), 64'(e.acc + 1));
                        check("frame_shape", 64'({bad, val[9], val[0]}),
                              64'(3'b010));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            en[i] = 1'b1;
        end
        apply_reset();

        push(0, 8'h41, 1'b1);
        drain(2 * (FRAME + 1), 1'b0);
        check("single_order", ord_code(), 64'h1);

        apply_reset();
        push(0, 8'h11, 1'b1); push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1); push(1, 8'h22, 1'b1);
        drain(5 * (FRAME + 1), 1'b0);
        check("rr_order", ord_code(), 64'h1212);
        check("rr_gap", 64'(gap(0, 3)), 64'(3 * (FRAME + 1)));

        apply_reset();
        push(0, 8'h48, 1'b0); push(0, 8'h49, 1'b1);
        push(1, 8'h5A, 1'b1);
        drain(4 * (FRAME + 1), 1'b0);
        check("lock_order", ord_code(), 64'h112);

        apply_reset();
        push(0, 8'hA5, 1'b0);
        push(1, 8'h3C, 1'b1);
        drain(3 * (FRAME + 1) + LT, 1'b0);
        check("tmo_order", ord_code(), 64'h12);
        check("tmo_gap", 64'(gap(0, 1)), 64'(FRAME + 1 + LT));

        apply_reset();
        push(0, 8'h96, 1'b1);
        wait_acc(0, 10);
        repeat (4 * C + C / 2 + 1) tick();
        check("mid_busy", 64'(busy), 64'(1));
        check("mid_bit3", 64'(ser_tx), 64'(0));
        push(0, 8'h55, 1'b1);
        apply_reset();
        drain(2 * (FRAME + 1), 1'b0);
        check("post_rst_order", ord_code(), 64'h1);

        apply_reset();
        push(2, 8'h77, 1'b1);
        drain(2 * (FRAME + 1), 1'b0);
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        drain(3 * (FRAME + 1), 1'b0);
        check("wrap_order", ord_code(), 64'h341);

        apply_reset();
        churn = 1'b1;
        for (int i = 0; i < NR; i++) begin
            for (int m = 0; m < 2; m++) begin
                int len;
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++)
                    push(i, 8'($urandom), 1'(b == len - 1));
            end
        end
        drain(30 * (FRAME + 1), 1'b1);
        churn = 1'b0;
        repeat (4) tick();
        check("leftover", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single SoC serial transmit line (ser_tx) between several byte producers, e.g. the CPU UART register port and the network accelerator's debug/status stream. Each requester offers bytes through a valid/ready handshake. The block arbitrates round-robin with optional multi-byte message locking and serialises the granted byte as 8N1, LSB first. It sits between the requesters and the ser_tx pad, replacing a per-master UART transmitter.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
CLKS_PER_BIT, 106, clock cycles per serial bit (start, data and stop); legal 4..65535
LOCK_TIMEOUT, 4096, idle cycles after which a held message lock is forcibly released (legal >= 1)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active-low
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  byte is the last of its message; 0 requests a lock
req_ready  output  NUM_REQ  one-cycle accept strobe; transfer occurs when valid & ready
ser_tx  output  1  serial line, idle high
busy  output  1  high while a frame (start..stop) is on the line
grant_id  output  3  index of the requester whose byte is currently or was last transmitted
locked  output  1  message lock currently held by grant_id

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low; all state updates on the rising edge of clk.
- Reset values: ser_tx=1, busy=0, req_ready=0, grant_id=0, locked=0, round-robin pointer=0, state=IDLE, lock timer=0.
- States: IDLE, START, DATA, STOP.
- IDLE, unlocked:
  - Pick the first i with req_valid[i]=1, searching from pointer upward with wrap modulo NUM_REQ.
  - Assert req_ready[i] for that cycle only and capture req_data[i] and req_last[i].
  - Set grant_id=i and pointer=(i+1) mod NUM_REQ.
  - Set locked = !req_last[i]. Go to START.
- IDLE, locked: only requester grant_id is considered.
  - If it is valid, accept as above without advancing the pointer. locked follows the new req_last.
  - Otherwise increment the lock timer. When the timer reaches LOCK_TIMEOUT: clear locked, clear the timer, and arbitrate normally from the next cycle.
  - The timer clears on every accepted byte.
- At most one req_ready bit is high in any cycle. req_ready is never high outside IDLE.
- START: ser_tx=0 for CLKS_PER_BIT cycles. ser_tx falls in the cycle after the accept edge.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit counter 0..7 and a baud counter 0..CLKS_PER_BIT-1 wrap independently.
- STOP: ser_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Frame timing: the frame occupies exactly 10*CLKS_PER_BIT cycles. There is a minimum of one IDLE cycle between frames, so back-to-back accepts are 10*CLKS_PER_BIT+1 cycles apart.
- busy=1 from the first START cycle through the last STOP cycle, and 0 in IDLE.
- Requester inputs are ignored outside IDLE. Changing req_data while valid is held, before acceptance, is legal; the value sampled on the accept cycle is the one sent.
- Simultaneous valids: the requester nearest the pointer wins. Losers keep valid asserted and are served in later IDLE windows.
- Reset mid-frame: the line returns high on the next edge, the frame is abandoned, no req_ready is issued, and lock and pointer are cleared.
- The lock timer runs only in IDLE while locked.

Test Plan:
- Single byte: req_valid[0]=1, data 0x41, last=1 at cycle t.
  - req_ready[0] pulses at t; ser_tx=0 over t+1..t+106.
  - Data bits 1,0,0,0,0,0,1,0 follow, each 106 cycles; stop high for 106 cycles.
  - busy falls at t+1061; locked=0 throughout.
- Round-robin: both requesters valid continuously (req0 0x11, req1 0x22, last=1).
  - Line order is 0x11, 0x22, 0x11, 0x22; accepts are 1061 cycles apart; grant_id alternates 0,1,0,1.
- Lock: req0 sends 0x48 last=0, then 0x49 last=1, while req1 is valid with 0x5A.
  - Line order is 0x48, 0x49, 0x5A; locked is high during the 0x48 frame only.
- Lock timeout with LOCK_TIMEOUT=16: req0 sends last=0 then drops valid; req1 is valid.
  - req1 is not accepted until 16 IDLE cycles elapse.
  - Then locked=0 and req1's byte goes out.
- Reset mid-frame: resetn low during DATA bit 3.
  - Next edge: ser_tx=1, busy=0, req_ready=0.
  - After release, a new byte 0x55 transmits correctly.
- Wrap: NUM_REQ=4 with pointer=3 and requesters 0 and 3 valid.
  - Requester 3 is granted first, then requester 0; the pointer wraps to 0, then 1.
